// File: rtl/gcd_engine_if.sv
// Operand/result bundle between an operand source (master) and gcd_engine (slave).
interface gcd_engine_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] gcd_out;
  logic [WIDTH-1:0] iter_count;
  logic             zero_err;

  modport master (
    output start, a_in, b_in,
    input  busy, done, gcd_out, iter_count, zero_err
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, done, gcd_out, iter_count, zero_err
  );
endinterface

// File: rtl/gcd_engine.sv
// Subtractive GCD unit: one subtraction per clock, held result with
// iteration count and both-operands-zero flag.
module gcd_engine #(
  parameter int unsigned WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  gcd_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [WIDTH-1:0] iter_q, iter_d;
  logic             zerr_q, zerr_d;
  logic [WIDTH-1:0] iter_inc;

  // Counter sticks at all-ones rather than wrapping.
  assign iter_inc = (iter_q == '1) ? iter_q : iter_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      iter_q  <= '0;
      zerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      iter_q  <= iter_d;
      zerr_q  <= zerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    iter_d  = iter_q;
    zerr_d  = zerr_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          iter_d = '0;
          if (bus.a_in != '0 && bus.b_in != '0) begin
            a_d     = bus.a_in;
            b_d     = bus.b_in;
            zerr_d  = 1'b0;
            state_d = RUN;
          end else begin
            // With one operand zero the OR is simply the other operand.
            gcd_d   = bus.a_in | bus.b_in;
            zerr_d  = (bus.a_in == '0) && (bus.b_in == '0);
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (a_q == b_q) begin
          gcd_d   = a_q;
          state_d = DONE;
        end else if (a_q > b_q) begin
          a_d    = a_q - b_q;
          iter_d = iter_inc;
        end else begin
          b_d    = b_q - a_q;
          iter_d = iter_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.gcd_out    = gcd_q;
  assign bus.iter_count = iter_q;
  assign bus.zero_err   = zerr_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: directed vector table, hand-written
// corner sequences and random operands against a Euclid-based reference.
module tb_gcd_engine;
  localparam int unsigned WIDTH  = 16;
  localparam int          BUDGET = 70000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  gcd_engine_if #(.WIDTH(WIDTH)) bus ();

  gcd_engine #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned gcd;
    int unsigned iter;
    int unsigned zerr;
    int          lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Subtraction count via Euclid: each division step of quotient q stands for
  // q subtractions, except the final step stops once the operands are equal.
  task automatic ref_model(input int unsigned a, input int unsigned b,
                           output int unsigned g, output int unsigned it,
                           output int unsigned z, output int lat);
    int unsigned x, y, t, s;
    if (a == 0 || b == 0) begin
      g = a | b; it = 0; z = (a == 0 && b == 0) ? 1 : 0; lat = 0;
    end else begin
      x = a; y = b; s = 0;
      while (y != 0) begin
        s += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      g = x; it = s - 1; z = 0; lat = int'(it) + 1;
    end
  endtask

  // Called at a negedge. Accepts on the next posedge; lat counts edges after
  // the accepting edge until done is seen (0 = done right after accept).
  task automatic run_op(input int unsigned a, input int unsigned b, input bit glitch,
                        output int lat, output bit busy_ok);
    bus.start = 1'b1;
    bus.a_in  = a[WIDTH-1:0];
    bus.b_in  = b[WIDTH-1:0];
    @(negedge clk);
    bus.start = glitch;
    bus.a_in  = glitch ? 16'd100 : 16'($urandom);
    bus.b_in  = glitch ? 16'd75  : 16'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < BUDGET) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    if (bus.busy) busy_ok = 1'b0;
  endtask

  task automatic do_vec(input string name, input vec_t v, input bit glitch);
    int lat;
    bit bok;
    run_op(v.a, v.b, glitch, lat, bok);
    check({name, " latency"}, lat, v.lat);
    check({name, " gcd_out"}, bus.gcd_out, v.gcd);
    check({name, " iter_count"}, bus.iter_count, v.iter);
    check({name, " zero_err"}, bus.zero_err, v.zerr);
    check({name, " busy_profile"}, bok, 1);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset gcd_out", bus.gcd_out, 0);
    check("reset iter_count", bus.iter_count, 0);
    check("reset zero_err", bus.zero_err, 0);
    rst = 1'b0;
    @(negedge clk);

    vecs.push_back('{12, 8, 4, 2, 0, 3});
    vecs.push_back('{7, 7, 7, 0, 0, 1});
    vecs.push_back('{0, 9, 9, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0});
    vecs.push_back('{48, 18, 6, 4, 0, 5});
    vecs.push_back('{9, 0, 9, 0, 0, 0});
    vecs.push_back('{1, 65535, 1, 65534, 0, 65535});
    vecs.push_back('{65535, 1, 1, 65534, 0, 65535});
    foreach (vecs[i]) do_vec($sformatf("vec%0d", i), vecs[i], 1'b0);

    // Outputs hold in DONE while start stays low.
    repeat (3) @(negedge clk);
    check("hold gcd_out", bus.gcd_out, 1);
    check("hold iter_count", bus.iter_count, 65534);
    check("hold done", bus.done, 1);

    // Second start while RUN must be ignored.
    do_vec("ignore_start", '{12, 8, 4, 2, 0, 3}, 1'b1);

    // Reset in the middle of a run.
    bus.start = 1'b1; bus.a_in = 16'd100; bus.b_in = 16'd75;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", bus.busy, 0);
    check("midrst done", bus.done, 0);
    check("midrst gcd_out", bus.gcd_out, 0);
    check("midrst iter_count", bus.iter_count, 0);
    check("midrst zero_err", bus.zero_err, 0);
    rst = 1'b0;
    do_vec("after_rst", '{9, 6, 3, 2, 0, 3}, 1'b0);

    // Back-to-back from DONE: nonzero drops done, zero path keeps it.
    do_vec("b2b_first", '{21, 14, 7, 2, 0, 3}, 1'b0);
    do_vec("b2b_nonzero", '{21, 14, 7, 2, 0, 3}, 1'b0);
    do_vec("b2b_zero", '{0, 5, 5, 0, 0, 0}, 1'b0);
    do_vec("b2b_bothzero", '{0, 0, 0, 0, 1, 0}, 1'b0);
    do_vec("clear_zerr", '{5, 0, 5, 0, 0, 0}, 1'b0);

    for (int i = 0; i < 40; i++) begin
      v.a = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 400);
      v.b = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 400);
      ref_model(v.a, v.b, v.gcd, v.iter, v.zerr, v.lat);
      do_vec($sformatf("rand%0d(%0d,%0d)", i, v.a, v.b), v, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
